// File: rtl/pet_bus_pkg.sv
// Shared types and default PET memory map for the CPU bus controller.
package pet_bus_pkg;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        COUNT = 2'd1,
        GO    = 2'd2
    } bus_state_t;

    localparam int         WAIT_W   = 3;
    localparam logic [7:0] PET_FILL = 8'h55;

    // Region order: 0 RAM, 1 VRAM, 2 IO, 3 ROM
    localparam logic [63:0] PET_BASE = {16'hC000, 16'hE800, 16'h8000, 16'h0000};
    localparam logic [63:0] PET_MASK = {16'hC000, 16'hF800, 16'hF800, 16'hC000};
    localparam logic [11:0] PET_WAIT = {3'd0, 3'd1, 3'd0, 3'd0};
    localparam logic [3:0]  PET_WR   = 4'b0111;

endpackage

// File: rtl/pet_bus_decode.sv
// Priority address matcher: addr -> one-hot sel, region index and hit.
// Purely combinational; the lowest matching region index wins.
module pet_bus_decode
    import pet_bus_pkg::*;
#(
    parameter int                   NREG     = 4,
    parameter int                   AW       = 16,
    parameter logic [NREG*AW-1:0]   REG_BASE = PET_BASE,
    parameter logic [NREG*AW-1:0]   REG_MASK = PET_MASK
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] sel,
    output logic [3:0]      idx,
    output logic            hit
);

    always_comb begin
        idx = 4'd0;
        hit = 1'b0;
        // Descending scan so the lowest matching index is the last writer.
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((addr & REG_MASK[i*AW +: AW]) == REG_BASE[i*AW +: AW]) begin
                idx = 4'(i);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            sel[i] = hit && (idx == 4'(i));
        end
    end

endmodule

// File: rtl/pet_bus_ctrl.sv
// CPU bus controller: region decode, per-region wait states, 1 MHz pacing, read mux, strobes.
// Latency: zero-wait regions complete combinationally under clk_speed; paced access rdy at ce_1m+2+W.
// Backpressure: clk_stop freezes the wait counter; optional write-protect fault via PET_BUS_WP_FAULT_EN.
module pet_bus_ctrl
    import pet_bus_pkg::*;
#(
    parameter int                       NREG     = 4,
    parameter int                       AW       = 16,
    parameter int                       DW       = 8,
    parameter logic [DW-1:0]            FILL     = PET_FILL,
    parameter logic [NREG*AW-1:0]       REG_BASE = PET_BASE,
    parameter logic [NREG*AW-1:0]       REG_MASK = PET_MASK,
    parameter logic [NREG*WAIT_W-1:0]   REG_WAIT = PET_WAIT,
    parameter logic [NREG-1:0]          REG_WR   = PET_WR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_1m,
    input  logic                clk_speed,
    input  logic                clk_stop,
    input  logic [AW-1:0]       addr,
    input  logic                we,
    input  logic [NREG*DW-1:0]  rd_data,
    output logic [DW-1:0]       data_out,
    output logic                rdy,
    output logic [NREG-1:0]     sel,
    output logic [NREG-1:0]     wr_en,
    output logic [NREG-1:0]     rd_stb,
    input  logic                wp_clr,
    output logic                wp_fault,
    output logic [AW-1:0]       wp_addr
);

    logic [3:0]         idx;
    logic               hit;
    logic [WAIT_W-1:0]  w_live;
    logic [DW-1:0]      dat;
    logic               tick_r;
    bus_state_t         state;
    logic [WAIT_W-1:0]  cnt;

    pet_bus_decode #(
        .NREG     (NREG),
        .AW       (AW),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_decode (
        .addr (addr),
        .sel  (sel),
        .idx  (idx),
        .hit  (hit)
    );

    always_comb begin
        w_live = '0;
        dat    = FILL;
        for (int i = 0; i < NREG; i++) begin
            if (hit && (idx == 4'(i))) begin
                w_live = REG_WAIT[i*WAIT_W +: WAIT_W];
                dat    = rd_data[i*DW +: DW];
            end
        end
    end

    assign data_out = dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r <= 1'b0;
            state  <= ARM;
            cnt    <= '0;
        end else begin
            tick_r <= (clk_speed | ce_1m) & ~clk_stop;
            case (state)
                ARM: begin
                    // The wait count is captured here, so later addr changes cannot alter it.
                    if (tick_r) begin
                        if (w_live == '0) begin
                            state <= GO;
                        end else begin
                            cnt   <= w_live;
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (!clk_stop) begin
                        cnt <= cnt - WAIT_W'(1);
                        if (cnt == WAIT_W'(1)) begin
                            state <= GO;
                        end
                    end
                end
                GO:      state <= ARM;
                default: state <= ARM;
            endcase
        end
    end

    assign rdy = ~reset & ((state == GO) |
                 (clk_speed & ~clk_stop & (state == ARM) & (w_live == '0)));

    assign wr_en  = {NREG{we & rdy}} & sel & REG_WR;
    assign rd_stb = {NREG{~we & rdy}} & sel;

`ifdef PET_BUS_WP_FAULT_EN
    logic wp_hit;
    assign wp_hit = we & rdy & (|(sel & ~REG_WR));

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_fault <= 1'b0;
            wp_addr  <= '0;
        end else if (wp_hit) begin
            // A fault coinciding with wp_clr starts a fresh record.
            wp_fault <= 1'b1;
            if (!wp_fault || wp_clr) begin
                wp_addr <= addr;
            end
        end else if (wp_clr) begin
            wp_fault <= 1'b0;
            wp_addr  <= '0;
        end
    end
`else
    logic wp_clr_unused;
    assign wp_clr_unused = wp_clr;
    assign wp_fault      = 1'b0;
    assign wp_addr       = '0;
`endif

endmodule

// File: tb/tb_pet_bus_ctrl.sv
// Directed bench for pet_bus_ctrl; ROM (region 3) gets 3 wait states to exercise the counter.
module tb_pet_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_1m = 1'b0;
    logic        clk_speed = 1'b0;
    logic        clk_stop = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0;
    logic [31:0] rd_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [7:0]  data_out;
    logic        rdy;
    logic [3:0]  sel;
    logic [3:0]  wr_en;
    logic [3:0]  rd_stb;
    logic        wp_clr = 1'b0;
    logic        wp_fault;
    logic [15:0] wp_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pet_bus_ctrl #(
        .REG_WAIT ({3'd3, 3'd1, 3'd0, 3'd0})
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_1m     (ce_1m),
        .clk_speed (clk_speed),
        .clk_stop  (clk_stop),
        .addr      (addr),
        .we        (we),
        .rd_data   (rd_data),
        .data_out  (data_out),
        .rdy       (rdy),
        .sel       (sel),
        .wr_en     (wr_en),
        .rd_stb    (rd_stb),
        .wp_clr    (wp_clr),
        .wp_fault  (wp_fault),
        .wp_addr   (wp_addr)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    // Returns inside the first non-reset cycle; inputs set now apply to that cycle.
    task automatic do_reset();
        nxt();
        reset = 1'b1; ce_1m = 1'b0; clk_speed = 1'b0; clk_stop = 1'b0;
        we = 1'b0; wp_clr = 1'b0; addr = 16'h0000;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        nxt();
        reset = 1'b1; clk_speed = 1'b1; addr = 16'h8000; we = 1'b1;
        nxt();
        nxt();
        #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got %b want 0000", wr_en); end
        checks++; if (rd_stb !== 4'b0000) begin errors++; $display("FAIL reset_rd_stb got %b want 0000", rd_stb); end
        checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL reset_wp_fault got %b want 0", wp_fault); end
        checks++; if (wp_addr !== 16'h0000) begin errors++; $display("FAIL reset_wp_addr got %h want 0000", wp_addr); end
        checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL reset_sel got %b want 0010", sel); end
        checks++; if (data_out !== 8'hB1) begin errors++; $display("FAIL reset_data got %h want b1", data_out); end
    endtask

    task automatic test_priority();
        logic [15:0] a_tab [8] = '{16'hE000, 16'hE800, 16'h5000, 16'h0123,
                                   16'h8400, 16'h8800, 16'hF000, 16'hEFFF};
        logic [3:0]  s_tab [8] = '{4'b1000, 4'b0100, 4'b0000, 4'b0001,
                                   4'b0010, 4'b0000, 4'b1000, 4'b0100};
        logic [7:0]  d_tab [8] = '{8'hD3, 8'hC2, 8'h55, 8'hA0,
                                   8'hB1, 8'h55, 8'hD3, 8'hC2};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            addr = a_tab[k];
            #1;
            checks++; if (sel !== s_tab[k]) begin errors++; $display("FAIL prio_sel addr=%h got %b want %b", a_tab[k], sel, s_tab[k]); end
            checks++; if (data_out !== d_tab[k]) begin errors++; $display("FAIL prio_data addr=%h got %h want %h", a_tab[k], data_out, d_tab[k]); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL prio_rdy addr=%h got %b want 0", a_tab[k], rdy); end
        end
    endtask

    task automatic test_slow_read();
        do_reset();
        addr = 16'h0123; we = 1'b0; clk_speed = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) nxt();
            ce_1m = (k == 10);
            #1;
            checks++; if (rdy !== (k == 12)) begin errors++; $display("FAIL slow_rdy clk=%0d got %b want %b", k, rdy, k == 12); end
            checks++; if (rd_stb !== ((k == 12) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL slow_rd_stb clk=%0d got %b", k, rd_stb); end
            checks++; if (data_out !== 8'hA0) begin errors++; $display("FAIL slow_data clk=%0d got %h want a0", k, data_out); end
        end
    endtask

    task automatic test_fast_io_write();
        do_reset();
        clk_speed = 1'b1; addr = 16'h0010; we = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fast_ram_rdy got %b want 1", rdy); end
        checks++; if (rd_stb !== 4'b0001) begin errors++; $display("FAIL fast_ram_rd_stb got %b want 0001", rd_stb); end
        // IO: one clk for the ARM latch, one wait clk, then GO.
        for (int k = 0; k < 3; k++) begin
            nxt();
            if (k == 0) begin addr = 16'hE810; we = 1'b1; end
            #1;
            checks++; if (rdy !== (k == 2)) begin errors++; $display("FAIL fast_io_rdy clk=%0d got %b want %b", k, rdy, k == 2); end
            checks++; if (wr_en !== ((k == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL fast_io_wr_en clk=%0d got %b", k, wr_en); end
            checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL fast_io_sel clk=%0d got %b want 0100", k, sel); end
        end
        nxt();
        we = 1'b0; addr = 16'h0010;
        #1;
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL fast_after_wr_en got %b want 0000", wr_en); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fast_after_rdy got %b want 1", rdy); end
    endtask

    task automatic test_clk_stop();
        do_reset();
        clk_speed = 1'b0; addr = 16'hE000; we = 1'b0;
        // Without the stall rdy would be at clk 5; three frozen clks push it to 8.
        for (int k = 0; k < 10; k++) begin
            if (k > 0) nxt();
            ce_1m    = (k == 0);
            clk_stop = ((k >= 2) && (k <= 4)) || (k == 8);
            #1;
            checks++; if (rdy !== (k == 8)) begin errors++; $display("FAIL stop_rdy clk=%0d got %b want %b", k, rdy, k == 8); end
            checks++; if (rd_stb !== ((k == 8) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL stop_rd_stb clk=%0d got %b", k, rd_stb); end
        end
        nxt();
        clk_stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        clk_speed = 1'b1; addr = 16'hE810; we = 1'b1;
        nxt();
        nxt();
        reset = 1'b1;
        #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy got %b want 0", rdy); end
        nxt();
        reset = 1'b0;
        #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mid_after_rdy got %b want 0", rdy); end
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL mid_after_wr_en got %b want 0000", wr_en); end
        nxt();
        addr = 16'h0200; we = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_ram_rdy got %b want 1", rdy); end
        checks++; if (rd_stb !== 4'b0001) begin errors++; $display("FAIL mid_ram_rd_stb got %b want 0001", rd_stb); end
    endtask

    task automatic test_unmapped_write();
        do_reset();
        clk_speed = 1'b0; addr = 16'h5000; we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            ce_1m = (k == 0);
            #1;
            checks++; if (rdy !== (k == 2)) begin errors++; $display("FAIL unmap_rdy clk=%0d got %b want %b", k, rdy, k == 2); end
            checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL unmap_wr_en clk=%0d got %b want 0000", k, wr_en); end
            checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL unmap_data clk=%0d got %h want 55", k, data_out); end
        end
    endtask

    task automatic test_wp();
        logic        done;
        logic        exp_f;
        logic [15:0] exp_a;
        do_reset();
        clk_speed = 1'b1; we = 1'b1; addr = 16'hF000;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (k > 0) nxt();
            #1;
            if (rdy) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL wp_wr1_timeout got no rdy want rdy within 20 clks"); end
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL wp_wr1_wr_en got %b want 0000", wr_en); end
        nxt();
        we = 1'b0; addr = 16'h0000;
        #1;
`ifdef PET_BUS_WP_FAULT_EN
        exp_f = 1'b1; exp_a = 16'hF000;
`else
        exp_f = 1'b0; exp_a = 16'h0000;
`endif
        checks++; if (wp_fault !== exp_f) begin errors++; $display("FAIL wp_fault1 got %b want %b", wp_fault, exp_f); end
        checks++; if (wp_addr !== exp_a) begin errors++; $display("FAIL wp_addr1 got %h want %h", wp_addr, exp_a); end
        nxt();
        we = 1'b1; addr = 16'hC004;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (k > 0) nxt();
            #1;
            if (rdy) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL wp_wr2_timeout got no rdy want rdy within 20 clks"); end
        nxt();
        we = 1'b0; addr = 16'h0000;
        #1;
        checks++; if (wp_fault !== exp_f) begin errors++; $display("FAIL wp_fault2 got %b want %b", wp_fault, exp_f); end
        checks++; if (wp_addr !== exp_a) begin errors++; $display("FAIL wp_addr2 got %h want %h", wp_addr, exp_a); end
        nxt();
        wp_clr = 1'b1;
        nxt();
        wp_clr = 1'b0;
        #1;
        checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL wp_clr_fault got %b want 0", wp_fault); end
        checks++; if (wp_addr !== 16'h0000) begin errors++; $display("FAIL wp_clr_addr got %h want 0000", wp_addr); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_priority();
        test_slow_read();
        test_fast_io_write();
        test_clk_stop();
        test_reset_mid();
        test_unmapped_write();
        test_wp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
